touch_event_gen: RTL and testbench

TOUCH_EVENT_GEN -- requirements
Module: touch_event_gen

---
 rtl/touch_event_gen.sv | 163 ++++++++++++++++
 tb/tb_touch_event_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_event_gen.sv
// Touch event generator: turns one-hot direction requests into timed press/release coordinate pulses.
// Optional 4-entry request FIFO is compiled in with `define TOUCH_EVENT_FIFO_EN.
module touch_event_gen #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] dir_req,
    input  logic       battle_en,
    output logic [7:0] x_hold,
    output logic [7:0] y_hold,
    output logic       touch_valid,
    output logic       req_err,
    output logic [1:0] dbg_state_o
);
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic       tv_q, tv_d, err_q, err_d;

    // Handshake: a request transfers on any rising clk edge where req_valid && req_ready.
    logic       deq_valid, deq;
    logic [3:0] deq_dir;
    logic       deq_battle;

    assign deq = (state_q == IDLE) && deq_valid;

`ifdef TOUCH_EVENT_FIFO_EN
    logic [4:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       enq;

    assign deq_valid              = (count_q != 3'd0);
    assign {deq_dir, deq_battle}  = fifo_q[rd_ptr_q];
    // When full, a same-cycle dequeue frees the slot being written.
    assign req_ready              = !reset && ((count_q != 3'd4) || deq);
    assign enq                    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= {dir_req, battle_en};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (deq) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, enq} - {2'b00, deq};
        end
    end
`else
    assign deq_valid  = req_valid;
    assign deq_dir    = dir_req;
    assign deq_battle = battle_en;
    assign req_ready  = !reset && (state_q == IDLE);
`endif

    logic       onehot, legal;
    logic [7:0] lx, ly;

    always_comb begin
        onehot = (deq_dir != 4'd0) && ((deq_dir & (deq_dir - 4'd1)) == 4'd0);
        legal  = onehot && !(deq_battle && (deq_dir[1] || deq_dir[0]));
        lx     = 8'd0;
        ly     = 8'd0;
        case (deq_dir)
            4'b1000: begin lx = deq_battle ? 8'd63 : 8'd105; ly = deq_battle ? 8'd7   : 8'd31;  end
            4'b0100: begin lx = deq_battle ? 8'd63 : 8'd105; ly = deq_battle ? 8'd180 : 8'd217; end
            4'b0001: begin lx = 8'd225; ly = 8'd113; end
            4'b0010: begin lx = 8'd44;  ly = 8'd113; end
            default: begin lx = 8'd0;   ly = 8'd0;   end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        tv_d    = tv_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (deq) begin
                    if (legal) begin
                        state_d = PRESS;
                        cnt_d   = HOLD_LD;
                        x_d     = lx;
                        y_d     = ly;
                        tv_d    = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (cnt_q <= 8'd1) begin
                    state_d = RELEASE;
                    cnt_d   = GAP_LD;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                    tv_d    = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            RELEASE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            tv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tv_q    <= tv_d;
            err_q   <= err_d;
        end
    end

    assign x_hold      = x_q;
    assign y_hold      = y_q;
    assign touch_valid = tv_q;
    assign req_err     = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_touch_event_gen.sv
// Bench for touch_event_gen: spec vector table, hand sequences, and random traffic against a timeline model.
// Define TOUCH_EVENT_FIFO_EN to exercise the FIFO build.
module tb_touch_event_gen;
    localparam int H = 16;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] dir_req = 4'd0;
    logic       battle_en = 1'b0;
    logic       req_ready, touch_valid, req_err;
    logic [7:0] x_hold, y_hold;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    touch_event_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .dir_req(dir_req), .battle_en(battle_en), .x_hold(x_hold), .y_hold(y_hold),
        .touch_valid(touch_valid), .req_err(req_err), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Timeline model: a legal dequeue at cycle c presses over c+1..c+H, releases for G cycles, idle from c+1+H+G.
    int         cyc = 0;
    int         free_at = 0;
    int         press_start = -1000;
    int         err_at = -1;
    logic [7:0] px = 8'd0, py = 8'd0;
    logic [4:0] pend[$];
    bit         last_acc = 1'b0;
    bit         prev_tv = 1'b0;
    bit         sb_on = 1'b0;
    logic [15:0] exp_q[$];

    function automatic bit legal(input logic [3:0] d, input logic b);
        int ones = $countones(d);
        return (ones == 1) && !(b && (d == 4'b0001 || d == 4'b0010));
    endfunction

    function automatic logic [15:0] coords(input logic [3:0] d, input logic b);
        case (d)
            4'b1000: return b ? {8'd63, 8'd7}   : {8'd105, 8'd31};
            4'b0100: return b ? {8'd63, 8'd180} : {8'd105, 8'd217};
            4'b0001: return {8'd225, 8'd113};
            4'b0010: return {8'd44, 8'd113};
            default: return 16'd0;
        endcase
    endfunction

    function automatic bit model_active();
        return ((cyc >= press_start) && (cyc < press_start + H)) || (cyc == err_at);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit         idle, exp_tv, exp_ready, deq;
        logic [4:0] item;
        @(negedge clk);
        idle   = (cyc >= free_at);
        exp_tv = (cyc >= press_start) && (cyc < press_start + H);
`ifdef TOUCH_EVENT_FIFO_EN
        exp_ready = !reset && ((pend.size() < 4) || (idle && pend.size() > 0));
`else
        exp_ready = !reset && idle;
`endif
        chk("touch_valid", touch_valid, exp_tv);
        chk("x_hold", x_hold, exp_tv ? px : 8'd0);
        chk("y_hold", y_hold, exp_tv ? py : 8'd0);
        chk("req_err", req_err, cyc == err_at);
        chk("req_ready", req_ready, exp_ready);
        chk("idle_state", dbg_state == 2'd0, idle);
        if (sb_on && touch_valid && !prev_tv) begin
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("press_order", {x_hold, y_hold}, exp_q.pop_front());
        end
        prev_tv  = touch_valid;
        last_acc = req_valid && exp_ready;
        if (reset) begin
            pend.delete();
            free_at     = cyc + 1;
            press_start = -1000;
            err_at      = -1;
        end else begin
            deq  = 1'b0;
            item = 5'd0;
`ifdef TOUCH_EVENT_FIFO_EN
            if (idle && pend.size() > 0) begin
                item = pend.pop_front();
                deq  = 1'b1;
            end
            if (last_acc) pend.push_back({dir_req, battle_en});
`else
            if (idle && req_valid) begin
                item = {dir_req, battle_en};
                deq  = 1'b1;
            end
`endif
            if (deq) begin
                if (legal(item[4:1], item[0])) begin
                    press_start = cyc + 1;
                    free_at     = cyc + 1 + H + G;
                    {px, py}    = coords(item[4:1], item[0]);
                end else begin
                    err_at = cyc + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [3:0] d, input logic b, input bit track);
        int n = 0;
        req_valid = 1'b1;
        dir_req   = d;
        battle_en = b;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        chk("send_accepted", last_acc, 1);
        req_valid = 1'b0;
        if (track && legal(d, b)) exp_q.push_back(coords(d, b));
    endtask

    task automatic wait_event();
        for (int k = 0; k < 8 && !model_active(); k++) step();
    endtask

    typedef struct {
        logic [3:0] dir;
        logic       bat;
        logic [7:0] x;
        logic [7:0] y;
        logic       err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'b1000, 1'b0, 8'd105, 8'd31,  1'b0};
        tbl[1] = '{4'b0100, 1'b0, 8'd105, 8'd217, 1'b0};
        tbl[2] = '{4'b0001, 1'b0, 8'd225, 8'd113, 1'b0};
        tbl[3] = '{4'b0010, 1'b0, 8'd44,  8'd113, 1'b0};
        tbl[4] = '{4'b1000, 1'b1, 8'd63,  8'd7,   1'b0};
        tbl[5] = '{4'b0100, 1'b1, 8'd63,  8'd180, 1'b0};
        tbl[6] = '{4'b0001, 1'b1, 8'd0,   8'd0,   1'b1};
        tbl[7] = '{4'b0101, 1'b0, 8'd0,   8'd0,   1'b1};
        tbl[8] = '{4'b0000, 1'b0, 8'd0,   8'd0,   1'b1};
        tbl[9] = '{4'b0010, 1'b1, 8'd0,   8'd0,   1'b1};

        // reset state, checked while reset is still held
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].dir, tbl[i].bat, 1'b0);
            wait_event();
            chk("tbl_x", x_hold, tbl[i].x);
            chk("tbl_y", y_hold, tbl[i].y);
            chk("tbl_touch", touch_valid, !tbl[i].err);
            chk("tbl_err", req_err, tbl[i].err);
            repeat (H + G + 2) step();
        end

        // battle_en and dir_req changes mid-press must not disturb the held coordinates
        send(4'b0100, 1'b1, 1'b0);
        wait_event();
        repeat (3) step();
        battle_en = 1'b0;
        dir_req   = 4'b1000;
        repeat (4) step();
        chk("battle_hold_x", x_hold, 63);
        chk("battle_hold_y", y_hold, 180);
        chk("battle_hold_tv", touch_valid, 1);
        repeat (H + G + 2) step();

        // reset at PRESS cycle 5, then a fresh request
        send(4'b1000, 1'b0, 1'b0);
        wait_event();
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_tv", touch_valid, 0);
        chk("abort_x", x_hold, 0);
        chk("abort_y", y_hold, 0);
        chk("abort_ready", req_ready, 1);
        send(4'b0010, 1'b0, 1'b0);
        wait_event();
        chk("after_reset_x", x_hold, 44);
        chk("after_reset_y", y_hold, 113);
        repeat (H + G + 2) step();

`ifdef TOUCH_EVENT_FIFO_EN
        // back-to-back requests while a press runs: four queue, the fifth stalls
        sb_on = 1'b1;
        exp_q.delete();
        send(4'b1000, 1'b0, 1'b1);
        wait_event();
        send(4'b0100, 1'b0, 1'b1);
        send(4'b0001, 1'b0, 1'b1);
        send(4'b0010, 1'b0, 1'b1);
        send(4'b1000, 1'b1, 1'b1);
        req_valid = 1'b1;
        dir_req   = 4'b0100;
        battle_en = 1'b1;
        #1;
        chk("fifo_full_ready", req_ready, 0);
        send(4'b0100, 1'b1, 1'b1);
        repeat ((H + G + 1) * 6) step();
        chk("sb_drained", exp_q.size(), 0);
        sb_on = 1'b0;
`endif

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0) dir_req = 4'b0001 << $urandom_range(0, 3);
            else dir_req = 4'($urandom_range(0, 15));
            battle_en = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
